uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single `uart_tx` serializer between several byte-stream requesters, such as the JSON motion-command generator and servo/status telemetry. It sits between the requesters and `uart_tx` on `CLOCK_50`. A grant is held for a whole packet, so frames from different sources never interleave on the UART line.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..8).
- `BITS_N`, 8: byte width; matches `uart_tx` `BITS_N`.
- `TIMEOUT_CYCLES`, 50_000: stall limit in clock cycles (1 ms at 50 MHz). Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `req_data` in N_REQ*BITS_N: requester i's byte is on bits [i*BITS_N +: BITS_N].
- `req_valid` in N_REQ: requester i has a byte.
- `req_last` in N_REQ: requester i's current byte ends its packet.
- `req_ready` out N_REQ: byte accepted from requester i when `req_valid[i] && req_ready[i]`.
- `tx_data` out BITS_N: to `uart_tx` `data_tx`.
- `tx_valid` out 1: to `uart_tx` `valid`.
- `tx_ready` in 1: from `uart_tx` `ready`.
- `grant` out N_REQ: one-hot, registered; current owner.
- `busy` out 1: high while a grant is held.
- `timeout_pulse` out 1: one-cycle pulse when a stalled packet is released.

## Operation
- Two states: IDLE and LOCK.
- Registers:
  - `state`
  - `grant`
  - `last_grant` (index)
  - timeout counter (only with the macro)
- IDLE behaviour:
  - `tx_valid`=0, all `req_ready`=0, `grant`=0, `busy`=0.
  - If any `req_valid` is high, choose the first requester with `req_valid` set, scanning from `last_grant+1` mod N_REQ upward.
  - Next cycle: `grant` = one-hot of the chosen requester, state = LOCK.
- LOCK behaviour, with owner g:
  - `tx_data` = `req_data[g]`, `tx_valid` = `req_valid[g]`.
  - `req_ready[g]` = `tx_ready`; all other `req_ready` = 0.
- Beat: `tx_valid && tx_ready`.
  - A beat with `req_last[g]`=1 sets state = IDLE, `grant` = 0, `last_grant` = g on the next edge.
  - A beat with `req_last[g]`=0 stays in LOCK.
- No preemption: if the owner drops `req_valid` mid-packet, the grant is still held. Other requesters wait.
- A single-byte packet (valid and last on its first beat) costs exactly one beat, then returns to IDLE.
- `req_last` is sampled only on beats.
- Requests that arrive during LOCK are not latched. They are re-evaluated in IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - `grant`=0, `busy`=0, `tx_valid`=0, `req_ready`=0, `timeout_pulse`=0.
  - `last_grant` = N_REQ-1, so requester 0 wins the first arbitration.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k gives a grant valid from k+1. The first byte can transfer in cycle k+1.
- The LOCK datapath is combinational pass-through: zero added latency, no byte buffering.
- Packet turnaround: at least 1 IDLE cycle after each last beat. Back-to-back packets from the same or a different source are separated by at least one cycle.
- Fairness: with all N_REQ requesting continuously, each gets exactly one packet per N_REQ packets.
- Reset in LOCK mid-packet: the arbiter drops to IDLE at the next edge. The partial packet is abandoned; the requester must re-send it.
- `tx_valid` must never rise while `grant` is 0.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined:
  - In LOCK, the counter increments each cycle with no beat and clears on every beat.
  - When it reaches TIMEOUT_CYCLES-1, the arbiter forces IDLE next edge, sets `last_grant` = g, and pulses `timeout_pulse` for 1 cycle.
  - The abandoned requester sees `req_ready` fall and must restart its packet.
- Undefined: no counter is built, `timeout_pulse` is tied 0, and the grant is held indefinitely.

## Structure
- Package `uart_arb_pkg`:
  - state enum `arb_state_t` {ARB_IDLE, ARB_LOCK}.
  - default constants `UART_ARB_N_REQ`=2, `UART_ARB_TIMEOUT_DEFAULT`=50_000.
  - function `rr_next(req, last_grant)` returning an index.
- One sub-module, `rr_priority_picker`: combinational. Takes `req` and `last_grant`; returns `pick_idx` and `pick_valid`.

## Test plan
- Reset then req0 sends 3 bytes 0x7B,0x22,0x7D (last on 0x7D), `tx_ready` always 1:
  - `grant`=01 one cycle after request.
  - `tx_data` shows the 3 bytes on consecutive cycles.
  - IDLE one cycle after 0x7D.
- req0 and req1 both assert in IDLE after reset: req0 wins. After its packet, req1 is granted with no further req0 packet in between.
- req1 owner, `tx_ready` toggling 1/0 each cycle (UART busy):
  - bytes transfer only on `tx_ready`=1.
  - `req_ready[1]` mirrors `tx_ready`.
  - `req_ready[0]`=0 throughout.
- Owner drops `req_valid` after the first of 4 bytes while req1 requests:
  - grant unchanged, `tx_valid`=0, no req1 byte is emitted.
  - With macro, `TIMEOUT_CYCLES`=16: `timeout_pulse` 16 cycles after the stall, then req1 is granted.
- `rst` asserted on the second byte of a packet: `grant`=0, `tx_valid`=0 the next cycle. The next arbitration favours requester 0.
- Single-byte packets, requesters 0 and 1 continuously valid, 10 packets: grants alternate 0,1,0,1… with exactly one IDLE cycle between packets.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types, default constants and the round-robin helper for the UART
// transmit arbiter.
//
// Contents:
//   arb_state_t               arbiter FSM encoding (IDLE / LOCK)
//   UART_ARB_N_REQ            default requester count
//   UART_ARB_TIMEOUT_DEFAULT  default stall limit in clock cycles
//   UART_ARB_MAX_REQ          largest supported requester count
//   rr_next()                 round-robin pick starting after last_grant
// ----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned UART_ARB_N_REQ           = 2;
    localparam int unsigned UART_ARB_TIMEOUT_DEFAULT = 50_000;
    localparam int unsigned UART_ARB_MAX_REQ         = 8;

    // Returns the first index with req set, scanning from last_grant+1
    // upward modulo n_req. last_grant itself is examined last, so a lone
    // requester can win back-to-back. Returns last_grant when nothing is set.
    function automatic logic [2:0] rr_next(
        input logic [UART_ARB_MAX_REQ-1:0] req,
        input logic [2:0]                  last_grant,
        input int unsigned                 n_req
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last_grant;
        found = 1'b0;
        for (int unsigned k = 1; k <= UART_ARB_MAX_REQ; k++) begin
            if (k <= n_req) begin
                idx = (32'(last_grant) + k) % n_req;
                if (!found && req[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin selector used by uart_tx_arbiter in IDLE.
//
// Ports:
//   req_i         in  N_REQ  request vector (req_valid of each requester)
//   last_grant_i  in  IDXW   index of the previous packet owner
//   pick_idx_o    out IDXW   winning index (meaningful when pick_valid_o)
//   pick_valid_o  out 1      at least one request present
// ----------------------------------------------------------------------------
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ = UART_ARB_N_REQ,
    parameter int unsigned IDXW  = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDXW-1:0]  last_grant_i,
    output logic [IDXW-1:0]  pick_idx_o,
    output logic             pick_valid_o
);

    // Operands are widened to the helper's fixed 8-requester width; the
    // result always fits back into IDXW because it is < N_REQ.
    assign pick_idx_o   = IDXW'(rr_next(UART_ARB_MAX_REQ'(req_i),
                                        3'(last_grant_i), N_REQ));
    assign pick_valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Packet-level round-robin arbiter in front of a single uart_tx serializer.
// A grant is held for a whole packet so frames from different requesters
// never interleave on the line. The datapath in LOCK is a pure
// combinational pass-through of the owner's byte stream.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN): stall watchdog. In LOCK a
// cycle without a beat counts toward TIMEOUT_CYCLES; on expiry the packet is
// abandoned, the arbiter returns to IDLE and timeout_pulse_o fires once.
// Without the macro no counter exists and timeout_pulse_o is tied low.
//
// Ports:
//   clk_i            in  1              system clock
//   rst_i            in  1              synchronous active-high reset
//   req_data_i       in  N_REQ*BITS_N   requester i byte at [i*BITS_N +: BITS_N]
//   req_valid_i      in  N_REQ          requester i has a byte
//   req_last_i       in  N_REQ          requester i's byte ends its packet
//   req_ready_o      out N_REQ          byte taken from requester i
//   tx_data_o        out BITS_N         to uart_tx data_tx
//   tx_valid_o       out 1              to uart_tx valid
//   tx_ready_i       in  1              from uart_tx ready
//   grant_o          out N_REQ          one-hot registered owner
//   busy_o           out 1              grant held
//   timeout_pulse_o  out 1              stalled packet released (macro only)
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = UART_ARB_N_REQ,
    parameter int unsigned BITS_N         = 8,
    parameter int unsigned TIMEOUT_CYCLES = UART_ARB_TIMEOUT_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ*BITS_N-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [BITS_N-1:0]       tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    output logic                    timeout_pulse_o
);

    // state | meaning
    // ------+---------------------------------------------------------
    // IDLE  | no owner; arbitrate among req_valid_i, outputs quiet
    // LOCK  | owner holds the UART until its last beat (or a timeout)
    localparam logic [0:0] ST_IDLE = ARB_IDLE;
    localparam logic [0:0] ST_LOCK = ARB_LOCK;

    localparam int unsigned     IDXW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Starting at N_REQ-1 makes requester 0 the first winner after reset.
    localparam logic [IDXW-1:0] LAST_RESET = IDXW'(N_REQ - 1);

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0]  last_grant_q, last_grant_d;

    logic [IDXW-1:0]  owner_idx;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_valid;
    logic             in_lock;
    logic             beat;
    logic             last_beat;
    logic             stall_expire;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_picker (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .pick_idx_o   (pick_idx),
        .pick_valid_o (pick_valid)
    );

    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) owner_idx = IDXW'(i);
        end
    end

    assign in_lock = (state_q == ST_LOCK);

    // LOCK mode pass-through; IDLE keeps every handshake low so tx_valid_o
    // can never be high without a grant.
    always_comb begin
        tx_data_o   = '0;
        tx_valid_o  = 1'b0;
        req_ready_o = '0;
        if (in_lock) begin
            tx_data_o   = req_data_i[owner_idx*BITS_N +: BITS_N];
            tx_valid_o  = req_valid_i[owner_idx];
            req_ready_o = grant_q & {N_REQ{tx_ready_i}};
        end
    end

    assign beat      = tx_valid_o && tx_ready_i;
    assign last_beat = beat && req_last_i[owner_idx];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned     CNTW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(TIMEOUT_CYCLES - 1);

    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic            timeout_pulse_q;

    // Down-counter holds the remaining beat-less cycles; reaching zero on a
    // cycle that still has no beat is the TIMEOUT_CYCLES-th stalled cycle.
    assign stall_expire = in_lock && !beat && (stall_cnt_q == '0);

    always_comb begin
        stall_cnt_d = stall_cnt_q - CNTW'(1);
        if (!in_lock || beat || stall_expire) stall_cnt_d = CNT_LOAD;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q     <= CNT_LOAD;
            timeout_pulse_q <= 1'b0;
        end else begin
            stall_cnt_q     <= stall_cnt_d;
            timeout_pulse_q <= stall_expire;
        end
    end

    assign timeout_pulse_o = timeout_pulse_q;
`else
    assign stall_expire    = 1'b0;
    assign timeout_pulse_o = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_LOCK;
                    grant_d = N_REQ'(1) << pick_idx;
                end
            end
            ST_LOCK: begin
                // req_last_i only matters on a beat; a stalled owner keeps
                // the grant unless the watchdog is built and expires.
                if (last_beat || stall_expire) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_grant_d = owner_idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RESET;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = in_lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with two requesters and a 16-cycle
// stall limit. Inputs change 1 ns after the rising edge; outputs are
// checked a further 1 ns later, well before the next edge.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ          = 2;
    localparam int unsigned BITS_N         = 8;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [N_REQ*BITS_N-1:0] req_data_i;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_last_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [BITS_N-1:0]       tx_data_o;
    logic                    tx_valid_o;
    logic                    tx_ready_i;
    logic [N_REQ-1:0]        grant_o;
    logic                    busy_o;
    logic                    timeout_pulse_o;

    logic [7:0] d0, d1;
    assign req_data_i = {d1, d0};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(
        .N_REQ          (N_REQ),
        .BITS_N         (BITS_N),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_data_i      (req_data_i),
        .req_valid_i     (req_valid_i),
        .req_last_i      (req_last_i),
        .req_ready_o     (req_ready_o),
        .tx_data_o       (tx_data_o),
        .tx_valid_o      (tx_valid_o),
        .tx_ready_i      (tx_ready_i),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .timeout_pulse_o (timeout_pulse_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [7:0] pkt1 [3];
    int         idx;
    logic [1:0] exp_g;

    initial begin
        pkt1        = '{8'hB1, 8'hB2, 8'hB3};
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_last_i  = '0;
        d0          = '0;
        d1          = '0;
        tx_ready_i  = 1'b1;
        tick();
        tick();
        settle();
        check_eq("rst_grant",     grant_o,         2'b00);
        check_eq("rst_busy",      busy_o,          1'b0);
        check_eq("rst_tx_valid",  tx_valid_o,      1'b0);
        check_eq("rst_req_ready", req_ready_o,     2'b00);
        check_eq("rst_tpulse",    timeout_pulse_o, 1'b0);

        // Requester 0 sends 7B 22 7D.
        rst_i       = 1'b0;
        req_valid_i = 2'b01;
        d0          = 8'h7B;
        settle();
        check_eq("t1_idle_grant",    grant_o,     2'b00);
        check_eq("t1_idle_tx_valid", tx_valid_o,  1'b0);
        check_eq("t1_idle_ready",    req_ready_o, 2'b00);
        tick();
        settle();
        check_eq("t1_grant",    grant_o,    2'b01);
        check_eq("t1_busy",     busy_o,     1'b1);
        check_eq("t1_tx_valid", tx_valid_o, 1'b1);
        check_eq("t1_byte0",    tx_data_o,  8'h7B);
        tick();
        d0 = 8'h22;
        settle();
        check_eq("t1_byte1", tx_data_o, 8'h22);
        check_eq("t1_grant1", grant_o,  2'b01);
        tick();
        d0         = 8'h7D;
        req_last_i = 2'b01;
        settle();
        check_eq("t1_byte2",  tx_data_o,   8'h7D);
        check_eq("t1_ready2", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b00;
        req_last_i  = 2'b00;
        settle();
        check_eq("t1_end_grant", grant_o, 2'b00);
        check_eq("t1_end_busy",  busy_o,  1'b0);

        // Both request after reset: 0 first, then 1 even though 0 has more.
        rst_i = 1'b1;
        tick();
        rst_i       = 1'b0;
        req_valid_i = 2'b11;
        req_last_i  = 2'b00;
        d0          = 8'hA0;
        d1          = pkt1[0];
        tick();
        settle();
        check_eq("t2_grant0", grant_o,   2'b01);
        check_eq("t2_a0",     tx_data_o, 8'hA0);
        tick();
        d0         = 8'hA1;
        req_last_i = 2'b01;
        settle();
        check_eq("t2_a1",    tx_data_o,   8'hA1);
        check_eq("t2_ready", req_ready_o, 2'b01);
        tick();
        d0         = 8'hA2;
        req_last_i = 2'b00;
        settle();
        check_eq("t2_gap_grant",    grant_o,    2'b00);
        check_eq("t2_gap_tx_valid", tx_valid_o, 1'b0);
        tick();
        settle();
        check_eq("t2_grant1", grant_o, 2'b10);

        // Requester 1 owns the UART while tx_ready toggles.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            tx_ready_i    = (c % 2 == 1);
            d1            = pkt1[idx];
            req_last_i[1] = (idx == 2);
            settle();
            check_eq("t3_grant",     grant_o,     2'b10);
            check_eq("t3_tx_data",   tx_data_o,   pkt1[idx]);
            check_eq("t3_req_ready", req_ready_o, {tx_ready_i, 1'b0});
            if (tx_ready_i) idx++;
            tick();
        end
        tx_ready_i  = 1'b1;
        req_valid_i = 2'b01;
        req_last_i  = 2'b00;
        settle();
        check_eq("t3_end_grant", grant_o, 2'b00);

        // Requester 0 stalls after its first byte while requester 1 waits.
        tick();
        settle();
        check_eq("t4_grant", grant_o,   2'b01);
        check_eq("t4_a2",    tx_data_o, 8'hA2);
        req_valid_i = 2'b11;
        d1          = 8'hC0;
        tick();
        req_valid_i = 2'b10;
        settle();
        check_eq("t4_stall_grant", grant_o,     2'b01);
        check_eq("t4_stall_valid", tx_valid_o,  1'b0);
        check_eq("t4_stall_ready", req_ready_o, 2'b01);
`ifdef UART_ARB_TIMEOUT_EN
        for (int s = 0; s < TIMEOUT_CYCLES; s++) begin
            settle();
            check_eq("t4_hold_grant",  grant_o,         2'b01);
            check_eq("t4_hold_valid",  tx_valid_o,      1'b0);
            check_eq("t4_hold_tpulse", timeout_pulse_o, 1'b0);
            tick();
        end
        settle();
        check_eq("t4_tpulse",      timeout_pulse_o, 1'b1);
        check_eq("t4_tout_grant",  grant_o,         2'b00);
        tick();
        settle();
        check_eq("t4_tpulse_end",  timeout_pulse_o, 1'b0);
        check_eq("t4_req1_grant",  grant_o,         2'b10);
        check_eq("t4_req1_byte",   tx_data_o,       8'hC0);
        tick();
        d1    = 8'hC1;
        rst_i = 1'b1;
        settle();
        check_eq("t5_second_byte", tx_data_o, 8'hC1);
`else
        for (int s = 0; s < 20; s++) begin
            settle();
            check_eq("t4_hold_grant",  grant_o,         2'b01);
            check_eq("t4_hold_valid",  tx_valid_o,      1'b0);
            check_eq("t4_hold_ready",  req_ready_o,     2'b01);
            check_eq("t4_hold_tpulse", timeout_pulse_o, 1'b0);
            tick();
        end
        req_valid_i = 2'b11;
        d0          = 8'hA3;
        rst_i       = 1'b1;
        settle();
        check_eq("t5_second_byte", tx_data_o, 8'hA3);
`endif
        // Reset lands mid-packet; requester 0 must win the next arbitration.
        tick();
        settle();
        check_eq("t5_rst_grant", grant_o,    2'b00);
        check_eq("t5_rst_valid", tx_valid_o, 1'b0);
        rst_i       = 1'b0;
        req_valid_i = 2'b11;
        tick();
        settle();
        check_eq("t5_rearb", grant_o, 2'b01);

        // Single-byte packets from both requesters, ten packets.
        rst_i = 1'b1;
        tick();
        rst_i       = 1'b0;
        req_valid_i = 2'b11;
        req_last_i  = 2'b11;
        d0          = 8'h50;
        d1          = 8'h51;
        tx_ready_i  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (c % 2 == 0) exp_g = 2'b00;
            else            exp_g = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
            check_eq("t6_grant",    grant_o,    exp_g);
            check_eq("t6_tx_valid", tx_valid_o, (c % 2 == 1));
            if (c % 2 == 1)
                check_eq("t6_tx_data", tx_data_o, (exp_g == 2'b01) ? 8'h50 : 8'h51);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
